// File: rtl/sync_mod_counter_if.sv
// Control and status bundle of one sync_mod_counter stage; master drives the
// controls, slave is the counter itself.
interface sync_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output q, tc, wrap
    );
endinterface

// File: rtl/sync_mod_counter.sv
// Modulo-MODULUS up/down counter with clamped parallel load, cascadable tc and wrap pulse.
// Latency: q and wrap update 1 clk after the controlling edge; tc is combinational.
// Backpressure: none; en gates counting, so chaining tc into the next en builds multi-digit counters.
module sync_mod_counter #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic              clk,
    input  logic              rst,
    sync_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
        $error("sync_mod_counter: illegal WIDTH=%0d MODULUS=%0d", WIDTH, MODULUS);
    end

    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nxt;

    assign at_top       = (bus.q == MAXV);
    assign at_bot       = (bus.q == '0);
    // Out-of-range loads saturate so q can never leave 0..MODULUS-1.
    assign load_clamped = (bus.load_val > MAXV) ? MAXV : bus.load_val;
    assign count_nxt    = bus.up ? (at_top ? '0   : bus.q + WIDTH'(1))
                                 : (at_bot ? MAXV : bus.q - WIDTH'(1));

    // Gated by rst so a downstream stage holds still while this one is in reset.
    assign bus.tc = rst & bus.en & ~bus.load & (bus.up ? at_top : at_bot);

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.q    <= '0;
            bus.wrap <= 1'b0;
        end else begin
            bus.wrap <= bus.tc;
            if (bus.load) begin
                bus.q <= load_clamped;
            end else if (bus.en) begin
                bus.q <= count_nxt;
            end
        end
    end
endmodule

// File: tb/tb_sync_mod_counter.sv
// Bench for sync_mod_counter: directed plan on a decade counter, a 2-digit cascade,
// and randomized traffic on decade and natural-binary instances against an arithmetic model.
module tb_sync_mod_counter;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    sync_mod_counter_if #(.WIDTH(4)) ia ();
    sync_mod_counter_if #(.WIDTH(3)) ib ();
    sync_mod_counter_if #(.WIDTH(4)) c0 ();
    sync_mod_counter_if #(.WIDTH(4)) c1 ();

    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a  (.clk(clk), .rst(rst), .bus(ia));
    sync_mod_counter #(.WIDTH(3), .MODULUS(8))  dut_b  (.clk(clk), .rst(rst), .bus(ib));
    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) stage0 (.clk(clk), .rst(rst), .bus(c0));
    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) stage1 (.clk(clk), .rst(rst), .bus(c1));

    assign c0.en       = 1'b1;
    assign c0.up       = 1'b1;
    assign c0.load     = 1'b0;
    assign c0.load_val = '0;
    assign c1.en       = c0.tc;
    assign c1.up       = 1'b1;
    assign c1.load     = 1'b0;
    assign c1.load_val = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next value from the counting rules, as plain modular arithmetic.
    function automatic int nxt_val(int q, bit en, bit up, bit ld, int lv, int m);
        if (ld) return (lv > m - 1) ? m - 1 : lv;
        if (!en) return q;
        return up ? (q + 1) % m : (q + m - 1) % m;
    endfunction

    // A wrap is a counting step that went backwards (up) or forwards (down).
    function automatic bit wrapped(int q, int nq, bit en, bit up, bit ld);
        return en && !ld && (up ? (nq < q) : (nq > q));
    endfunction

    function automatic bit exp_tc(int q, bit r, bit en, bit up, bit ld, int m);
        return r && wrapped(q, nxt_val(q, en, up, ld, 0, m), en, up, ld);
    endfunction

    int ma_q, mb_q, mc_q, tmp_n, edges;
    bit ma_w, mb_w, mc_w, mc_w0, mvalid;

    initial begin
        mvalid = 0;
        edges  = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                ma_q = 0; mb_q = 0; mc_q = 0;
                ma_w = 0; mb_w = 0; mc_w = 0; mc_w0 = 0;
                edges  = 0;
                mvalid = 1;
            end else begin
                tmp_n = nxt_val(ma_q, ia.en, ia.up, ia.load, int'(ia.load_val), 10);
                ma_w  = wrapped(ma_q, tmp_n, ia.en, ia.up, ia.load);
                ma_q  = tmp_n;
                tmp_n = nxt_val(mb_q, ib.en, ib.up, ib.load, int'(ib.load_val), 8);
                mb_w  = wrapped(mb_q, tmp_n, ib.en, ib.up, ib.load);
                mb_q  = tmp_n;
                tmp_n = (mc_q + 1) % 100;
                mc_w  = tmp_n < mc_q;
                mc_w0 = (tmp_n % 10) < (mc_q % 10);
                mc_q  = tmp_n;
                edges++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                chk("a_q", 64'(ia.q), 64'(ma_q));
                chk("a_wrap", 64'(ia.wrap), 64'(ma_w));
                chk("a_tc", 64'(ia.tc), 64'(exp_tc(ma_q, rst, ia.en, ia.up, ia.load, 10)));
                chk("b_q", 64'(ib.q), 64'(mb_q));
                chk("b_wrap", 64'(ib.wrap), 64'(mb_w));
                chk("b_tc", 64'(ib.tc), 64'(exp_tc(mb_q, rst, ib.en, ib.up, ib.load, 8)));
                chk("casc_q", 64'(c1.q) * 10 + 64'(c0.q), 64'(mc_q));
                chk("casc_wrap0", 64'(c0.wrap), 64'(mc_w0));
                chk("casc_wrap1", 64'(c1.wrap), 64'(mc_w));
                if (rst && edges == 99) begin
                    chk("casc_lit99_q1", 64'(c1.q), 64'd9);
                    chk("casc_lit99_tc0", 64'(c0.tc), 64'd1);
                end
                if (rst && edges == 100) begin
                    chk("casc_lit100_q", 64'(c1.q) * 10 + 64'(c0.q), 64'd0);
                    chk("casc_lit100_wrap1", 64'(c1.wrap), 64'd1);
                end
            end
        end
    end

    task automatic drive(input bit e, input bit u, input bit l, input int lv);
        ia.en = e; ia.up = u; ia.load = l; ia.load_val = 4'(lv);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps;
        int first_wrap;
        int last_wrap;
        rst = 1'b0;
        ia.en = 1; ia.up = 1; ia.load = 1; ia.load_val = 4'd7;
        ib.en = 1; ib.up = 1; ib.load = 0; ib.load_val = 3'd0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_q", 64'(ia.q), 64'd0);
        chk("rst_wrap", 64'(ia.wrap), 64'd0);
        chk("rst_tc_load", 64'(ia.tc), 64'd0);
        ia.load = 0; ia.up = 0;
        #1;
        chk("rst_tc_gated", 64'(ia.tc), 64'd0);

        rst = 1'b1;
        drive(1, 1, 0, 0);
        chk("first_count", 64'(ia.q), 64'd1);
        repeat (8) drive(1, 1, 0, 0);
        chk("up_q9", 64'(ia.q), 64'd9);
        chk("up_tc9", 64'(ia.tc), 64'd1);
        drive(1, 1, 0, 0);
        chk("up_wrap_q", 64'(ia.q), 64'd0);
        chk("up_wrap_pulse", 64'(ia.wrap), 64'd1);

        wraps = 0; first_wrap = -1; last_wrap = -1;
        for (int i = 0; i < 30; i++) begin
            drive(1, 1, 0, 0);
            if (ia.wrap === 1'b1) begin
                wraps++;
                if (first_wrap < 0) first_wrap = i;
                last_wrap = i;
            end
        end
        chk("up_3_wraps", 64'(wraps), 64'd3);
        chk("up_wrap_spacing", 64'(last_wrap - first_wrap), 64'd20);

        drive(1, 0, 1, 2);
        chk("down_load2", 64'(ia.q), 64'd2);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("down_q0", 64'(ia.q), 64'd0);
        chk("down_tc0", 64'(ia.tc), 64'd1);
        drive(1, 0, 0, 0);
        chk("down_wrap_q", 64'(ia.q), 64'd9);
        chk("down_wrap_pulse", 64'(ia.wrap), 64'd1);
        ia.up = 1;
        #1;
        chk("dirchg_tc", 64'(ia.tc), 64'd1);
        drive(1, 1, 0, 0);
        chk("dirchg_q", 64'(ia.q), 64'd0);
        chk("dirchg_wrap", 64'(ia.wrap), 64'd1);

        drive(1, 1, 1, 9);
        drive(1, 0, 0, 0);
        chk("rev_at_top_q", 64'(ia.q), 64'd8);
        chk("rev_at_top_wrap", 64'(ia.wrap), 64'd0);

        drive(1, 1, 1, 4);
        chk("load4", 64'(ia.q), 64'd4);
        drive(1, 1, 1, 13);
        chk("load_clamp", 64'(ia.q), 64'd9);
        ia.load_val = 4'd3;
        #1;
        chk("load_blocks_tc", 64'(ia.tc), 64'd0);
        drive(1, 1, 1, 3);
        chk("load_over_wrap_q", 64'(ia.q), 64'd3);
        chk("load_over_wrap_pulse", 64'(ia.wrap), 64'd0);

        drive(1, 1, 1, 5);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0);
            chk("hold_q", 64'(ia.q), 64'd5);
            chk("hold_tc", 64'(ia.tc), 64'd0);
            chk("hold_wrap", 64'(ia.wrap), 64'd0);
        end
        drive(1, 1, 0, 0);
        chk("resume_q", 64'(ia.q), 64'd6);

        for (int i = 0; i < 2500; i++) begin
            rst         = (i > 200 && $urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            ia.en       = ($urandom_range(0, 3) != 0);
            ia.up       = $urandom_range(0, 1) == 1;
            ia.load     = ($urandom_range(0, 7) == 0);
            ia.load_val = 4'($urandom_range(0, 15));
            ib.en       = ($urandom_range(0, 3) != 0);
            ib.up       = $urandom_range(0, 1) == 1;
            ib.load     = ($urandom_range(0, 9) == 0);
            ib.load_val = 3'($urandom_range(0, 7));
            @(posedge clk);
            #2;
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
